// File: rtl/dual_rail_tx_arb_pkg.sv
// rtl/dual_rail_tx_arb_pkg.sv - shared types and helpers for the dual-rail transmit arbiter
//
// Purpose: FSM state encoding, dual-rail encoder and round-robin pick.
// No ports (package).
package dual_rail_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SET  = 2'd1,
      RST  = 2'd2
   } dr_state_t;

   // Upper bounds for the helper functions; callers zero-extend and slice.
   localparam int DR_MAX_W   = 64;
   localparam int DR_MAX_REQ = 32;

   // Returns {d1, d0}: true rails carry the data, false rails its complement.
   function automatic logic [2*DR_MAX_W-1:0] dr_encode(input logic [DR_MAX_W-1:0] data);
      return {data, ~data};
   endfunction

   // First valid index searching last+1, last+2, ... modulo n.
   // Returns last unchanged when nothing is valid; callers gate on |valid.
   function automatic logic [4:0] rr_pick(input logic [DR_MAX_REQ-1:0] valid,
                                          input logic [4:0]            last,
                                          input int                    n);
      logic [4:0] pick;
      logic       found;
      int         idx;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= DR_MAX_REQ; k++) begin
         idx = (int'(last) + k) % n;
         if (k <= n && !found && valid[idx]) begin
            pick  = 5'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/dual_rail_tx_arb_sync_ff.sv
// rtl/dual_rail_tx_arb_sync_ff.sv - multi-flop synchronizer for an asynchronous level
//
// Purpose: brings an asynchronous single-bit level into the clk domain.
// Ports:
//   clk      in   clock
//   reset_n  in   synchronous active-low reset (flops clear to 0)
//   d        in   asynchronous level
//   q        out  synchronized level, sync_stages edges after d
module sync_ff #(
   parameter int sync_stages = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [sync_stages-1:0] sh;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sh <= '0;
      end else begin
         sh <= {sh[sync_stages-2:0], d};
      end
   end

   assign q = sh[sync_stages-1];

endmodule

// File: rtl/dual_rail_tx_arb.sv
// rtl/dual_rail_tx_arb.sv - round-robin arbiter driving a four-phase dual-rail channel
//
// Purpose: grants one requester at a time, sends its word as a dual-rail
// codeword, waits for ack, returns to spacer, waits for ack to fall.
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   in_valid/in_data   per-requester word offer (requester i at [i*width +: width])
//   in_ready           one-hot accept strobe, combinational in IDLE
//   req_d0/req_d1      false/true rails (registered)
//   ack                asynchronous channel acknowledge
//   grant_id           index of the requester owning the channel
//   busy               state is not IDLE
//   err                sticky handshake timeout flag
module dual_rail_tx_arb
   import dual_rail_pkg::*;
#(
   parameter  int width       = 8,
   parameter  int nreq        = 2,
   parameter  int sync_stages = 2,
   parameter  int timeout     = 0,
   localparam int id_w        = (nreq > 1) ? $clog2(nreq) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [nreq-1:0]       in_valid,
   input  logic [nreq*width-1:0] in_data,
   output logic [nreq-1:0]       in_ready,
   output logic [width-1:0]      req_d0,
   output logic [width-1:0]      req_d1,
   input  logic                  ack,
   output logic [id_w-1:0]       grant_id,
   output logic                  busy,
   output logic                  err
);

   localparam int cnt_w = (timeout > 0) ? $clog2(timeout + 1) + 1 : 1;

   dr_state_t              state, next_state;
   logic                   ack_s;
   logic [sync_stages-1:0] primed;
   logic [width-1:0]       word, sel_data, rail_src;
   logic [id_w-1:0]        last, pick_id;
   logic [cnt_w-1:0]       cnt;
   logic                   accept;
   logic [2*DR_MAX_W-1:0]  enc;

   sync_ff #(.sync_stages(sync_stages)) u_ack_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (ack),
      .q       (ack_s)
   );

   // The synchronizer flops clear to 0 in reset, so ack_s cannot be trusted
   // until the chain has refilled; without this a stale ack held through
   // reset release would look low and let a grant through.
   always_comb begin
      pick_id    = id_w'(rr_pick(DR_MAX_REQ'(in_valid), 5'(last), nreq));
      sel_data   = in_data[int'(pick_id)*width +: width];
      accept     = 1'b0;
      in_ready   = '0;
      next_state = state;
      case (state)
         IDLE: begin
            if (!ack_s && primed[sync_stages-1] && (|in_valid)) begin
               accept            = 1'b1;
               in_ready[pick_id] = 1'b1;
               next_state        = SET;
            end
         end
         SET:     if (ack_s)  next_state = RST;
         RST:     if (!ack_s) next_state = IDLE;
         default: next_state = IDLE;
      endcase
      rail_src = accept ? sel_data : word;
      enc      = dr_encode(DR_MAX_W'(rail_src));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         primed   <= '0;
         last     <= id_w'(nreq - 1);
         grant_id <= '0;
         word     <= '0;
         req_d0   <= '0;
         req_d1   <= '0;
         cnt      <= '0;
         err      <= 1'b0;
      end else begin
         state  <= next_state;
         primed <= {primed[sync_stages-2:0], 1'b1};
         if (accept) begin
            word     <= sel_data;
            last     <= pick_id;
            grant_id <= pick_id;
         end
         // Rails are loaded from the held word throughout SET, so they stay
         // constant; any other state shows the all-zero spacer.
         if (next_state == SET) begin
            req_d1 <= enc[DR_MAX_W +: width];
            req_d0 <= enc[0 +: width];
         end else begin
            req_d1 <= '0;
            req_d0 <= '0;
         end
         // Phase counter: cleared on state change, saturating in SET/RST.
         if (next_state != state) begin
            cnt <= '0;
         end else if (state != IDLE && cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
         // Set on the edge where the count reaches timeout.
         if (timeout != 0 && state != IDLE && next_state == state &&
             cnt == cnt_w'(timeout - 1)) begin
            err <= 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_dual_rail_tx_arb.sv
// tb/tb_dual_rail_tx_arb.sv - self-checking bench for dual_rail_tx_arb
module tb_dual_rail_tx_arb;

   localparam int W  = 8;
   localparam int N  = 2;
   localparam int S  = 2;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [N-1:0]   in_valid = '0;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   req_d0, req_d1;
   logic           ack = 1'b0;
   logic [0:0]     grant_id;
   logic           busy, err;

   always #5 clk = ~clk;

   dual_rail_tx_arb #(.width(W), .nreq(N), .sync_stages(S), .timeout(TO)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .req_d0   (req_d0),
      .req_d1   (req_d1),
      .ack      (ack),
      .grant_id (grant_id),
      .busy     (busy),
      .err      (err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0] valid;
      logic [7:0] d0;
      logic [7:0] d1;
      int         ack_dly;
      logic [1:0] exp_ready;
      logic       exp_gid;
      logic [7:0] exp_word;
   } vec_t;

   vec_t vecs[8];

   task automatic do_reset();
      @(posedge clk); #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (|in_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Entered at a negedge in SET; raises ack after dly cycles and checks both
   // handshake latencies (sync_stages edges plus one state edge each).
   task automatic finish_handshake(input string tag, input int dly);
      int n;
      repeat (dly) @(negedge clk);
      ack = 1'b1;
      n = 0;
      while ((req_d0 | req_d1) != '0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, " ack_rise_latency"}, n, S + 1);
      ack = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, " ack_fall_latency"}, n, S + 1);
   endtask

   task automatic xfer(input vec_t v, input string tag);
      bit ok;
      @(posedge clk); #1;
      in_valid = v.valid;
      in_data  = {v.d1, v.d0};
      wait_ready(ok);
      check({tag, " ready_seen"}, ok, 1);
      check({tag, " in_ready"}, in_ready, v.exp_ready);
      @(posedge clk); #1;
      in_valid = '0;
      in_data  = '1;
      if (!ok) return;
      @(negedge clk);
      check({tag, " rails_set"}, {req_d1, req_d0}, {v.exp_word, ~v.exp_word});
      check({tag, " grant_id"}, grant_id, v.exp_gid);
      check({tag, " busy"}, busy, 1);
      repeat (v.ack_dly) @(negedge clk);
      check({tag, " rails_hold"}, {req_d1, req_d0}, {v.exp_word, ~v.exp_word});
      finish_handshake(tag, 0);
   endtask

   initial begin
      bit         ok;
      int         cnt;
      logic [7:0] exp_q[$];
      int         received, overlap, wrong, cyc, ph, dly;
      bit         acc[N];

      vecs[0] = '{2'b01, 8'hA5, 8'h00, 1, 2'b01, 1'b0, 8'hA5};
      vecs[1] = '{2'b10, 8'h00, 8'hC3, 0, 2'b10, 1'b1, 8'hC3};
      vecs[2] = '{2'b11, 8'h11, 8'h22, 2, 2'b01, 1'b0, 8'h11};
      vecs[3] = '{2'b11, 8'h11, 8'h22, 0, 2'b10, 1'b1, 8'h22};
      vecs[4] = '{2'b11, 8'h11, 8'h22, 3, 2'b01, 1'b0, 8'h11};
      vecs[5] = '{2'b11, 8'h11, 8'h22, 1, 2'b10, 1'b1, 8'h22};
      vecs[6] = '{2'b10, 8'h00, 8'hFF, 0, 2'b10, 1'b1, 8'hFF};
      vecs[7] = '{2'b01, 8'h00, 8'h77, 0, 2'b01, 1'b0, 8'h00};

      // Reset state
      @(negedge clk);
      check("reset rails", {req_d1, req_d0}, 16'h0);
      check("reset in_ready", in_ready, 0);
      check("reset grant_id", grant_id, 0);
      check("reset busy", busy, 0);
      check("reset err", err, 0);
      do_reset();

      for (int i = 0; i < 8; i++) xfer(vecs[i], $sformatf("vec%0d", i));

      // Stale ack held through reset release
      ack      = 1'b1;
      in_valid = 2'b01;
      in_data  = 16'h0077;
      do_reset();
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (|in_ready) cnt++;
      end
      check("stale no_ready", cnt, 0);
      ack = 1'b0;
      @(negedge clk);
      check("stale ready_after_1", in_ready, 2'b00);
      @(negedge clk);
      check("stale ready_after_2", in_ready, 2'b01);
      @(posedge clk); #1 in_valid = '0;
      @(negedge clk);
      check("stale rails", {req_d1, req_d0}, 16'h7788);
      finish_handshake("stale", 2);

      // Reset while rails show 3C
      @(posedge clk); #1;
      in_valid = 2'b01;
      in_data  = 16'h003C;
      wait_ready(ok);
      check("midset ready_seen", ok, 1);
      @(posedge clk); #1 in_valid = '0;
      @(negedge clk);
      check("midset rails", {req_d1, req_d0}, 16'h3CC3);
      reset_n = 1'b0;
      @(negedge clk);
      check("midset rails_zero", {req_d1, req_d0}, 16'h0);
      check("midset busy", busy, 0);
      check("midset grant_id", grant_id, 0);
      check("midset in_ready", in_ready, 0);
      check("midset err", err, 0);
      @(posedge clk); #1 reset_n = 1'b1;
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if ((req_d0 | req_d1) != '0 || busy) cnt++;
      end
      check("midset no_resend", cnt, 0);

      // Timeout with ack never rising
      @(posedge clk); #1;
      in_valid = 2'b01;
      in_data  = 16'h005A;
      wait_ready(ok);
      check("timeout ready_seen", ok, 1);
      @(posedge clk); #1 in_valid = '0;
      cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if ({req_d1, req_d0} !== 16'h5AA5) cnt++;
         if (k == 15) check("timeout err_before", err, 0);
         if (k == 17) check("timeout err_set", err, 1);
      end
      check("timeout rails_hold", cnt, 0);
      check("timeout err_stays", err, 1);
      finish_handshake("timeout", 0);
      check("timeout err_sticky", err, 1);
      do_reset();
      @(negedge clk);
      check("timeout err_cleared", err, 0);

      // Random traffic with random ack delays
      received = 0; overlap = 0; wrong = 0; cyc = 0; ph = 0; dly = 0;
      while (received < 1000 && cyc < 50000) begin
         @(negedge clk);
         cyc++;
         if ((req_d0 & req_d1) != '0) overlap++;
         for (int i = 0; i < N; i++) begin
            acc[i] = in_valid[i] & in_ready[i];
            if (acc[i]) exp_q.push_back(in_data[i*W +: W]);
         end
         case (ph)
            0: if ((req_d0 | req_d1) == 8'hFF) begin
                  if (exp_q.size() == 0) wrong++;
                  else if (req_d1 !== exp_q.pop_front()) wrong++;
                  received++;
                  dly = $urandom_range(10);
                  ph  = 1;
               end
            1: if (dly == 0) begin ack = 1'b1; ph = 2; end else dly--;
            2: if ((req_d0 | req_d1) == '0) begin dly = $urandom_range(10); ph = 3; end
            default: if (dly == 0) begin ack = 1'b0; ph = 0; end else dly--;
         endcase
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i] || !in_valid[i]) begin
               in_valid[i]        = 1'($urandom_range(1));
               in_data[i*W +: W]  = 8'($urandom);
            end
         end
      end
      check("rand words_received", received, 1000);
      check("rand word_mismatches", wrong, 0);
      check("rand rail_overlap", overlap, 0);
      check("rand queue_empty", exp_q.size(), 0);
      check("rand err", err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dual_rail_tx_arb.md
# dual_rail_tx_arb

Clocked arbiter and sequencer that shares one dual-rail, four-phase return-to-zero output channel among `nreq` synchronous requesters. It accepts a word from one requester at a time under round-robin priority and drives it onto `req_d0`/`req_d1` as a dual-rail codeword. It waits for the channel `ack`, returns the rails to the all-zero spacer, and waits for `ack` to fall before it grants again. It sits at the boundary between the clocked test environment or host logic and the asynchronous Balsa AES datapath inputs.

## Interface
- `width`, 8, data bits per word (dual-rail pairs on the channel)
- `nreq`, 2, number of requesters (>=1)
- `sync_stages`, 2, flops in the `ack` synchronizer (>=2)
- `timeout`, 0, max cycles to wait in either handshake phase; 0 disables the check
- `clk`  input  1  clock; all logic on rising edge
- `reset_n`  input  1  synchronous, active-low reset
- `in_valid`  input  nreq  per-requester word available
- `in_data`  input  nreq*width  requester i data at bits [i*width +: width]
- `in_ready`  output  nreq  one-hot accept strobe; word taken when `in_valid[i] & in_ready[i]`
- `req_d0`  output  width  false rails
- `req_d1`  output  width  true rails
- `ack`  input  1  asynchronous channel acknowledge
- `grant_id`  output  $clog2(nreq) (min 1)  index of the requester currently owning the channel
- `busy`  output  1  high whenever the state is not IDLE
- `err`  output  1  sticky timeout flag

## Operation
- **Reset values:** all outputs are 0. The state is IDLE. The round-robin pointer `last` is nreq-1, so requester 0 has first priority. The synchronizer flops are 0. `err` is 0.
- `ack` passes through `sync_stages` flops to form `ack_s`. Only `ack_s` is used by the logic.
- **IDLE:**
  - When `ack_s`==0 and any `in_valid` is high, pick the first valid index searching `last+1, last+2, …` modulo nreq.
  - Assert that requester's `in_ready` combinationally in the same cycle.
  - Register its data into `word`, and set `last` and `grant_id` to the index.
  - Go to SET.
  - If `ack_s`==1 in IDLE (for example a stale ack after reset), grant nothing.
- **SET:**
  - `req_d1` = `word` and `req_d0` = ~`word`, both registered, so exactly one rail of every pair is high.
  - When `ack_s`==1, go to RST.
- **RST:**
  - `req_d0` = `req_d1` = 0.
  - When `ack_s`==0, go to IDLE.
- **Timeout:** a phase counter clears on every state change and increments in SET and RST.
  - If `timeout`!=0 and the count reaches `timeout`, set `err` until reset. The FSM keeps waiting and does not abort.
  - The counter saturates and does not wrap.
- The rails are never driven with both `req_d0[i]` and `req_d1[i]` high. The rails never change while in SET.
- `in_data` is sampled only on the accept cycle. Requesters may change it afterwards.
- **Reset mid-operation:** the rails go to 0 on the next edge. The held word is lost and not re-sent. The next grant waits for `ack_s`==0.

## Timing
- **Accept:** cycle T (in IDLE, `in_ready` high). Rails show the codeword from T+1.
- **Ack rise:** an ack rising before edge E is seen as `ack_s`=1 after `sync_stages` edges. The rails are zero on the following edge.
- **Ack fall:** the same synchronizer latency applies to reach IDLE. The earliest next accept is the first IDLE cycle.
- **Minimum cycle** per word, with ack responding instantly: 2*(sync_stages+1)+1 cycles.
- **Simultaneous valids:** exactly one `in_ready` is asserted. The others wait.
- **Continuous valids:** requesters are served strictly in rotation.
- A requester deasserting `in_valid` before being granted is permitted. No accept is recorded for it.

## Structure
- **Shared package `dual_rail_pkg`:** state encoding (IDLE, SET, RST) and a `dr_encode` function (data -> {d1, d0}).
- **Sub-module `sync_ff`** (parameter `sync_stages`): instantiated for `ack`.
- The round-robin pick is a function in the package, not a separate module.

## Test plan
- **Single word:** after reset, assert `in_valid[0]` with data 8'hA5, and an ack model (1-cycle response).
  - Required: `in_ready[0]` pulses once.
  - Required: rails become d1=A5, d0=5A, then all-zero.
  - Required: `busy` falls after ack drops.
- **Round robin:** nreq=2, both valid continuously, data 8'h11 / 8'h22.
  - Required: the channel carries 11, 22, 11, 22.
  - Required: `grant_id` alternates 0, 1, 0, 1.
- **Stale ack:** hold `ack`=1 through reset release with `in_valid[0]` high.
  - Required: no `in_ready` until `ack` is low for `sync_stages` cycles, then a normal transfer.
- **Reset mid-SET:** pull `reset_n` low while the rails show 8'h3C.
  - Required: the rails are 0 on the next edge.
  - Required: all outputs are 0 and there is no retransmission of 3C.
- **Timeout:** `timeout`=16, `ack` never rises.
  - Required: `err` sets in the 16th SET cycle and stays high.
  - Required: the rails hold the codeword.
- **Rail invariant:** random valids, data, and ack delays (0–10 cycles) for 1000 words.
  - Required: `req_d0 & req_d1` is never nonzero.
  - Required: the received words equal the accepted words in order.
